mux_rr_arb: RTL

MUX_RR_ARB -- requirements
Module: mux_rr_arb

---
 rtl/mux_rr_arb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-channel to 1 multiplexer with a single registered output entry.
// Grant source is selectable per cycle: manual index (mode = 0) or
// round-robin starting at ptr (mode = 1). Full throughput: a word can drain
// and a new one load in the same clock.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    N*SIZE packed channel data, channel k at [k*SIZE +: SIZE]
//   in_valid   per-channel offer
//   in_ready   per-channel accept (combinational, at most one bit high)
//   mode       0 = manual select via S, 1 = round-robin
//   S          manual channel select (ignored when mode = 1)
//   out_data   registered selected data
//   out_sel    channel index out_data came from
//   out_valid  output entry holds an undelivered word
//   out_ready  downstream accept
module mux_rr_arb #(
    parameter int SIZE = 4,
    parameter int N    = 4,
    parameter int SW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*SIZE-1:0] in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic              mode,
    input  logic [SW-1:0]     S,
    output logic [SIZE-1:0]   out_data,
    output logic [SW-1:0]     out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    // Round-robin pointer: first channel searched on the next round-robin grant
    logic [SW-1:0]   ptr;

    // Entry is empty or being drained this cycle, so it may be (re)loaded
    logic            load_en;

    // Per-mode grant candidates
    logic            man_gnt;
    logic [SW-1:0]   man_idx;
    logic            rr_gnt;
    logic [SW-1:0]   rr_idx;

    // Selected grant for this cycle
    logic            gnt_vld;
    logic [SW-1:0]   gnt_idx;
    logic [SIZE-1:0] gnt_data;
    logic            accept;
    logic [SW-1:0]   next_ptr;

    assign load_en = !out_valid || out_ready;

    // Manual grant: match S against each legal index; an out-of-range S
    // matches nothing and therefore never grants.
    always_comb begin
        man_gnt = 1'b0;
        man_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (S == SW'(k) && in_valid[k]) begin
                man_gnt = 1'b1;
                man_idx = SW'(k);
            end
        end
    end

    // Round-robin grant: first valid channel at ptr, ptr+1, ... wrapping mod N.
    // ptr is always < N, so one conditional subtract is enough for the wrap.
    always_comb begin
        int cand;
        rr_gnt = 1'b0;
        rr_idx = '0;
        cand   = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!rr_gnt && in_valid[cand]) begin
                rr_gnt = 1'b1;
                rr_idx = SW'(cand);
            end
        end
    end

    // Mode is applied combinationally so a change affects this cycle's grant
    always_comb begin
        if (mode) begin
            gnt_vld = rr_gnt;
            gnt_idx = rr_idx;
        end else begin
            gnt_vld = man_gnt;
            gnt_idx = man_idx;
        end
    end

    // Data of the granted channel
    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_idx == SW'(k)) begin
                gnt_data = in_data[k*SIZE +: SIZE];
            end
        end
    end

    // A transfer in happens only outside reset, with room, and with a grant
    assign accept = !rst && load_en && gnt_vld;

    // One-hot accept back to the granted channel
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = accept && (gnt_idx == SW'(k));
        end
    end

    // Pointer advances past the granted channel, wrapping N-1 -> 0
    assign next_ptr = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);

    // Output entry and pointer; reset discards any pending word
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            out_valid <= gnt_vld;
            if (gnt_vld) begin
                out_data <= gnt_data;
                out_sel  <= gnt_idx;
                ptr      <= next_ptr;
            end
        end
    end

endmodule
